// File: rtl/psa_ram_port.sv
// Sample-RAM access stage: serialises host register accesses and playback
// fetches onto the single external SRAM port with a cycle-exact FSM.
module psa_ram_port #(
  parameter int AW            = 11,
  parameter int STROBE_CYCLES = 2
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  input  logic [7:0]    i_WDATA,
  input  logic          i_ADDR_LO_WE,
  input  logic          i_ADDR_HI_WE,
  input  logic          i_DATA_WE,
  input  logic          i_DATA_RE,
  input  logic          i_AUTOINC,
  input  logic          i_FETCH_REQ,
  input  logic [AW-1:0] i_FA,
  input  logic [7:0]    i_RAM_Q,
  output logic          o_nRAM_CS,
  output logic          o_nRAM_WR,
  output logic [AW-1:0] o_CA,
  output logic [7:0]    o_CD,
  output logic          o_CD_OE,
  output logic [7:0]    o_RDATA,
  output logic          o_RDATA_VLD,
  output logic [7:0]    o_FETCH_DATA,
  output logic          o_FETCH_ACK,
  output logic          o_BUSY,
  output logic          o_OVERRUN
);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_ADDR, R_LATCH, F_ADDR, F_LATCH
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(STROBE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    wBuf_q, wBuf_d;
  logic          pendW_q, pendW_d;
  logic          pendR_q, pendR_d;
  logic [AW-1:0] ca_q, ca_d;
  logic [7:0]    cd_q, cd_d;
  logic [7:0]    rData_q;
  logic          rDataVld_q;
  logic [7:0]    fetchData_q;
  logic          fetchAck_q;
  logic          overrun_q;

  logic hostState;
  logic busy;
  logic accW, accR, drop;
  logic wantW, wantR;
  logic hostDone;

  // Host request acceptance: one outstanding op, a write beats a same-cycle read
  always_comb begin
    hostState = (state_q == W_SETUP) || (state_q == W_PULSE) || (state_q == W_HOLD) ||
                (state_q == R_ADDR)  || (state_q == R_LATCH);
    busy  = pendW_q | pendR_q | hostState;
    accW  = i_DATA_WE & ~busy;
    accR  = i_DATA_RE & ~busy & ~i_DATA_WE;
    drop  = (i_DATA_WE & busy) | (i_DATA_RE & (busy | i_DATA_WE));
    wantW = pendW_q | accW;
    wantR = pendR_q | accR;
  end

  // Next-state logic: arbitration in IDLE (fetch first), strobe timing otherwise
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pendW_d  = wantW;
    pendR_d  = wantR;
    wBuf_d   = accW ? i_WDATA : wBuf_q;
    ca_d     = ca_q;
    cd_d     = cd_q;
    hostDone = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_FETCH_REQ && !fetchAck_q) begin
          state_d = F_ADDR;
          ca_d    = i_FA;
          cnt_d   = CNT_INIT;
        end else if (wantW) begin
          state_d = W_SETUP;
          ca_d    = ptr_q;
          cd_d    = wBuf_d;
          pendW_d = 1'b0;
        end else if (wantR) begin
          state_d = R_ADDR;
          ca_d    = ptr_q;
          cnt_d   = CNT_INIT;
          pendR_d = 1'b0;
        end
      end
      W_SETUP: begin
        state_d = W_PULSE;
        cnt_d   = CNT_INIT;
      end
      W_PULSE: begin
        if (cnt_q == 3'd0) state_d = W_HOLD;
        else               cnt_d   = cnt_q - 3'd1;
      end
      W_HOLD: begin
        state_d  = IDLE;
        hostDone = 1'b1;
      end
      R_ADDR: begin
        if (cnt_q == 3'd0) state_d = R_LATCH;
        else               cnt_d   = cnt_q - 3'd1;
      end
      R_LATCH: begin
        state_d  = IDLE;
        hostDone = 1'b1;
      end
      F_ADDR: begin
        if (cnt_q == 3'd0) state_d = F_LATCH;
        else               cnt_d   = cnt_q - 3'd1;
      end
      F_LATCH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address pointer: loads win over auto-increment on host-access completion
  always_comb begin
    ptr_d = ptr_q;
    if (i_ADDR_LO_WE || i_ADDR_HI_WE) begin
      if (i_ADDR_LO_WE) ptr_d[7:0]    = i_WDATA;
      if (i_ADDR_HI_WE) ptr_d[AW-1:8] = i_WDATA[AW-9:0];
    end else if (hostDone && i_AUTOINC) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  // State, pointer, pending flags and all registered outputs
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      ptr_q       <= '0;
      wBuf_q      <= 8'd0;
      pendW_q     <= 1'b0;
      pendR_q     <= 1'b0;
      ca_q        <= '0;
      cd_q        <= 8'd0;
      rData_q     <= 8'd0;
      rDataVld_q  <= 1'b0;
      fetchData_q <= 8'd0;
      fetchAck_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      wBuf_q      <= wBuf_d;
      pendW_q     <= pendW_d;
      pendR_q     <= pendR_d;
      ca_q        <= ca_d;
      cd_q        <= cd_d;
      rDataVld_q  <= (state_q == R_LATCH);
      fetchAck_q  <= (state_q == F_LATCH);
      overrun_q   <= drop;
      if (state_q == R_LATCH) rData_q     <= i_RAM_Q;
      if (state_q == F_LATCH) fetchData_q <= i_RAM_Q;
    end
  end

  // SRAM strobes decoded from the state; write enable only inside W_PULSE
  always_comb begin
    o_nRAM_CS = (state_q == IDLE);
    o_nRAM_WR = (state_q != W_PULSE);
    o_CD_OE   = (state_q == W_SETUP) || (state_q == W_PULSE) || (state_q == W_HOLD);
  end

  assign o_CA         = ca_q;
  assign o_CD         = cd_q;
  assign o_RDATA      = rData_q;
  assign o_RDATA_VLD  = rDataVld_q;
  assign o_FETCH_DATA = fetchData_q;
  assign o_FETCH_ACK  = fetchAck_q;
  assign o_BUSY       = busy;
  assign o_OVERRUN    = overrun_q;

endmodule

// File: tb/tb_psa_ram_port.sv
// Directed bench for psa_ram_port with a behavioural SRAM model.
module tb_psa_ram_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wData;
  logic        loWe, hiWe, dataWe, dataRe, autoInc, fetchReq;
  logic [10:0] fa;
  logic [7:0]  ramQ;
  logic        nCs, nWr, cdOe, rdVld, fAck, busy, ovr;
  logic [10:0] ca;
  logic [7:0]  cd, rdata, fData;

  logic [7:0]  mem [0:2047];
  int          checks = 0;
  int          failures = 0;
  int          wrLowCnt = 0;
  int          ovrCnt = 0;
  int          protoErr = 0;

  typedef struct {
    logic        loWe, hiWe, dataWe, dataRe;
    logic [7:0]  wData;
    logic        expNcs, expNwr, expOe, expBusy, expOvr, expVld;
    logic [10:0] expCa;
    logic [7:0]  expCd, expRdata;
  } vec_t;

  vec_t vecs [16];

  psa_ram_port #(.AW(11), .STROBE_CYCLES(2)) dut (
    .i_CLK(clk), .i_RST(rst), .i_WDATA(wData),
    .i_ADDR_LO_WE(loWe), .i_ADDR_HI_WE(hiWe),
    .i_DATA_WE(dataWe), .i_DATA_RE(dataRe), .i_AUTOINC(autoInc),
    .i_FETCH_REQ(fetchReq), .i_FA(fa), .i_RAM_Q(ramQ),
    .o_nRAM_CS(nCs), .o_nRAM_WR(nWr), .o_CA(ca), .o_CD(cd), .o_CD_OE(cdOe),
    .o_RDATA(rdata), .o_RDATA_VLD(rdVld), .o_FETCH_DATA(fData),
    .o_FETCH_ACK(fAck), .o_BUSY(busy), .o_OVERRUN(ovr)
  );

  always #5 clk = ~clk;

  assign ramQ = mem[ca];

  // SRAM model: write on every clock edge with CS and WR both asserted
  always @(posedge clk) begin
    if (!nCs && !nWr) mem[ca] <= cd;
  end

  // Strobe monitor sampled mid-cycle
  always @(negedge clk) begin
    if (!nWr) wrLowCnt++;
    if (ovr) ovrCnt++;
    if (!nWr && nCs) protoErr++;
  end

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    loWe = v.loWe; hiWe = v.hiWe; dataWe = v.dataWe; dataRe = v.dataRe; wData = v.wData;
    stepCycle();
    loWe = 1'b0; hiWe = 1'b0; dataWe = 1'b0; dataRe = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput({name, " idle"}, busy, 1'b0);
  endtask

  task automatic loadPtr(input logic [10:0] val);
    loWe = 1'b1; wData = val[7:0];
    stepCycle();
    loWe = 1'b0; hiWe = 1'b1; wData = {5'd0, val[10:8]};
    stepCycle();
    hiWe = 1'b0;
  endtask

  task automatic hostWrite(input logic [7:0] d, input string name);
    dataWe = 1'b1; wData = d;
    stepCycle();
    dataWe = 1'b0;
    waitIdle(name);
  endtask

  task automatic hostRead(input logic [10:0] expCa, input logic [7:0] exp, input string name);
    int n = 0;
    dataRe = 1'b1;
    stepCycle();
    dataRe = 1'b0;
    checkOutput({name, " addr"}, ca, expCa);
    while (!rdVld && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput({name, " vld"}, rdVld, 1'b1);
    checkOutput({name, " data"}, rdata, exp);
    stepCycle();
    checkOutput({name, " vld pulse"}, rdVld, 1'b0);
  endtask

  initial begin
    int snapWr, snapOvr, n;
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i) ^ 8'h5A;

    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h34, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 11'h000,8'h00,8'h00};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,8'h05, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 11'h000,8'h00,8'h00};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,8'hA5, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 11'h534,8'hA5,8'h00};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 11'h534,8'hA5,8'h00};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 11'h534,8'hA5,8'h00};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 11'h534,8'hA5,8'h00};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 11'h534,8'hA5,8'h00};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 11'h535,8'hA5,8'h00};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 11'h535,8'hA5,8'h00};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 11'h535,8'hA5,8'h00};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 11'h535,8'hA5,8'h6F};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 11'h535,8'hA5,8'h6F};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 11'h536,8'hA5,8'h6F};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 1'b0,1'b1,1'b0,1'b1,1'b1,1'b0, 11'h536,8'hA5,8'h6F};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 11'h536,8'hA5,8'h6F};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 11'h536,8'hA5,8'h6C};

    rst = 1'b1; wData = 8'h00; loWe = 1'b0; hiWe = 1'b0; dataWe = 1'b0; dataRe = 1'b0;
    autoInc = 1'b1; fetchReq = 1'b0; fa = 11'h000;
    repeat (2) stepCycle();
    rst = 1'b0;

    checkOutput("reset nCS", nCs, 1'b1);
    checkOutput("reset nWR", nWr, 1'b1);
    checkOutput("reset CA", ca, 11'h000);
    checkOutput("reset CD", cd, 8'h00);
    checkOutput("reset OE", cdOe, 1'b0);
    checkOutput("reset RDATA", rdata, 8'h00);
    checkOutput("reset VLD", rdVld, 1'b0);
    checkOutput("reset FDATA", fData, 8'h00);
    checkOutput("reset ACK", fAck, 1'b0);
    checkOutput("reset BUSY", busy, 1'b0);
    checkOutput("reset OVR", ovr, 1'b0);

    // Table: pointer load, write with auto-increment, reads and a dropped read
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d nCS", i), nCs, vecs[i].expNcs);
      checkOutput($sformatf("vec%0d nWR", i), nWr, vecs[i].expNwr);
      checkOutput($sformatf("vec%0d OE", i), cdOe, vecs[i].expOe);
      checkOutput($sformatf("vec%0d BUSY", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d OVR", i), ovr, vecs[i].expOvr);
      checkOutput($sformatf("vec%0d VLD", i), rdVld, vecs[i].expVld);
      checkOutput($sformatf("vec%0d CA", i), ca, vecs[i].expCa);
      checkOutput($sformatf("vec%0d CD", i), cd, vecs[i].expCd);
      checkOutput($sformatf("vec%0d RDATA", i), rdata, vecs[i].expRdata);
    end
    checkOutput("table mem 0x534", mem[11'h534], 8'hA5);

    // Pointer wrap on auto-increment, then read back both bytes
    autoInc = 1'b1;
    loadPtr(11'h7FF);
    hostWrite(8'h11, "wrap wr1");
    hostWrite(8'h22, "wrap wr2");
    checkOutput("wrap mem 0x7FF", mem[11'h7FF], 8'h11);
    checkOutput("wrap mem 0x000", mem[11'h000], 8'h22);
    loadPtr(11'h7FF);
    hostRead(11'h7FF, 8'h11, "wrap rd1");
    hostRead(11'h000, 8'h22, "wrap rd2");

    // Fetch wins arbitration; ack cycle must not re-grant the held request
    autoInc = 1'b0;
    loadPtr(11'h200);
    snapOvr = ovrCnt;
    fetchReq = 1'b1; fa = 11'h100; dataWe = 1'b1; wData = 8'h77;
    stepCycle();
    dataWe = 1'b0;
    checkOutput("arb fetch CA", ca, 11'h100);
    checkOutput("arb fetch OE", cdOe, 1'b0);
    checkOutput("arb BUSY pending", busy, 1'b1);
    n = 0;
    while (!fAck && n < 10) begin
      stepCycle();
      n++;
    end
    checkOutput("arb ACK", fAck, 1'b1);
    checkOutput("arb FDATA", fData, 8'h5A);
    checkOutput("arb ack nCS", nCs, 1'b1);
    stepCycle();
    fetchReq = 1'b0;
    checkOutput("arb ACK pulse", fAck, 1'b0);
    checkOutput("arb write nCS", nCs, 1'b0);
    checkOutput("arb write OE", cdOe, 1'b1);
    checkOutput("arb write CA", ca, 11'h200);
    checkOutput("arb write CD", cd, 8'h77);
    waitIdle("arb write");
    checkOutput("arb mem 0x200", mem[11'h200], 8'h77);
    checkOutput("arb no overrun", ovrCnt - snapOvr, 0);

    // Second write while busy is dropped with a single overrun pulse
    snapWr = wrLowCnt;
    snapOvr = ovrCnt;
    dataWe = 1'b1; wData = 8'h3C;
    stepCycle();
    dataWe = 1'b0;
    stepCycle();
    dataWe = 1'b1; wData = 8'hC3;
    stepCycle();
    dataWe = 1'b0;
    checkOutput("ovr pulse", ovr, 1'b1);
    stepCycle();
    checkOutput("ovr pulse end", ovr, 1'b0);
    waitIdle("ovr write");
    repeat (3) stepCycle();
    checkOutput("ovr count", ovrCnt - snapOvr, 1);
    checkOutput("ovr WR low cycles", wrLowCnt - snapWr, 2);
    checkOutput("ovr mem 0x200", mem[11'h200], 8'h3C);

    // Reset during the write pulse aborts the access and clears the pointer
    dataWe = 1'b1; wData = 8'h99;
    stepCycle();
    dataWe = 1'b0;
    stepCycle();
    checkOutput("rst in pulse nWR", nWr, 1'b0);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("rst nWR", nWr, 1'b1);
    checkOutput("rst nCS", nCs, 1'b1);
    checkOutput("rst BUSY", busy, 1'b0);
    snapWr = wrLowCnt;
    repeat (6) stepCycle();
    checkOutput("rst no WR pulse", wrLowCnt - snapWr, 0);
    checkOutput("rst no ACK", fAck, 1'b0);
    hostRead(11'h000, 8'h22, "rst ptr read");

    // Pointer load during an in-flight write with auto-increment off
    autoInc = 1'b0;
    loadPtr(11'h005);
    dataWe = 1'b1; wData = 8'hE7;
    stepCycle();
    dataWe = 1'b0;
    loWe = 1'b1; wData = 8'h10;
    stepCycle();
    loWe = 1'b0;
    checkOutput("load inflight CA", ca, 11'h005);
    waitIdle("load inflight");
    checkOutput("load mem 0x005", mem[11'h005], 8'hE7);
    hostRead(11'h010, 8'h4A, "load rd1");
    hostRead(11'h010, 8'h4A, "load rd2");

    checkOutput("WR low with CS high", protoErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psa_ram_port.md
Name: psa_ram_port

Overview:
- Sample-RAM access stage directly downstream of the PSA register decoder.
- Takes decoded host strobes (address-pointer load, data write, data read) and the playback engine's fetch requests.
- Serialises both sources onto the single external SRAM port (o_nRAM_CS, o_nRAM_WR, o_CA, o_CD) under a cycle-exact FSM.
- Host pointer auto-increment allows streaming sample uploads through one data register.

Parameters:
- AW, 11: RAM address width. Equals the width of o_CA, i_FA and the pointer.
- STROBE_CYCLES, 2: clocks nRAM_WR is held low on a write, and clocks address is held before data is latched on a read or fetch. Legal range 1..7.

Ports:
- i_CLK  in  1  system clock; all state changes on rising edge.
- i_RST  in  1  synchronous active-high reset.
- i_WDATA  in  8  host write data from register decoder.
- i_ADDR_LO_WE  in  1  one-cycle pulse: ptr[7:0] <= i_WDATA.
- i_ADDR_HI_WE  in  1  one-cycle pulse: ptr[AW-1:8] <= i_WDATA[AW-9:0].
- i_DATA_WE  in  1  one-cycle pulse: host RAM write request.
- i_DATA_RE  in  1  one-cycle pulse: host RAM read request.
- i_AUTOINC  in  1  level: increment ptr after each completed host access.
- i_FETCH_REQ  in  1  playback fetch request; level, held until o_FETCH_ACK.
- i_FA  in  AW  playback fetch address; valid while i_FETCH_REQ=1.
- i_RAM_Q  in  8  SRAM read data.
- o_nRAM_CS  out  1  SRAM chip select, active low.
- o_nRAM_WR  out  1  SRAM write enable, active low.
- o_CA  out  AW  SRAM address.
- o_CD  out  8  SRAM write data.
- o_CD_OE  out  1  write-data drive enable.
- o_RDATA  out  8  last host read result.
- o_RDATA_VLD  out  1  one-cycle pulse when o_RDATA updates.
- o_FETCH_DATA  out  8  fetched byte.
- o_FETCH_ACK  out  1  one-cycle pulse when o_FETCH_DATA updates.
- o_BUSY  out  1  host operation pending or in flight.
- o_OVERRUN  out  1  one-cycle pulse when a host request is dropped.

Behaviour:
- Reset values:
  - o_nRAM_CS=1, o_nRAM_WR=1, o_CA=0, o_CD=0, o_CD_OE=0.
  - o_RDATA=0, o_RDATA_VLD=0, o_FETCH_DATA=0, o_FETCH_ACK=0, o_BUSY=0, o_OVERRUN=0.
  - ptr=0, FSM=IDLE, pending cleared.
- Reset mid-operation: the next edge forces IDLE and the reset outputs, with no completing write pulse and no ack.
- Pointer:
  - Both load strobes in the same cycle apply together.
  - A load takes effect the next cycle even while busy.
  - An in-flight access uses the address captured at grant.
  - Auto-increment: ptr <= ptr+1 mod 2^AW on host-access completion, only when i_AUTOINC=1 and no load strobe is present that cycle (load wins).
- Host requests:
  - DATA_WE latches i_WDATA into wbuf and sets pend_w.
  - DATA_RE sets pend_r.
  - Only one host operation is outstanding. A DATA_WE or DATA_RE while o_BUSY=1 is dropped with an o_OVERRUN pulse.
  - DATA_WE and DATA_RE in the same cycle: the write is accepted and the read is dropped with o_OVERRUN.
  - o_BUSY rises the cycle after acceptance and falls the cycle after completion.
- Arbitration in IDLE: i_FETCH_REQ has priority over a pending host operation. Grant is evaluated every IDLE cycle, so there are no wait cycles between back-to-back operations.
- Write FSM:
  - W_SETUP (1 clk): CS=0, WR=1, CA=ptr, CD=wbuf, OE=1.
  - W_PULSE (STROBE_CYCLES): WR=0.
  - W_HOLD (1 clk): WR=1, CS=0, OE=1.
  - Then IDLE: CS=1, OE=0.
  - Total is STROBE_CYCLES+2 clocks.
- Read FSM:
  - R_ADDR (STROBE_CYCLES): CS=0, CA=ptr.
  - R_LATCH (1 clk): o_RDATA <= i_RAM_Q, o_RDATA_VLD=1 next cycle.
  - Then IDLE.
- Fetch FSM:
  - F_ADDR (STROBE_CYCLES): CS=0, CA=i_FA captured at grant.
  - F_LATCH (1 clk): o_FETCH_DATA <= i_RAM_Q, o_FETCH_ACK=1 next cycle.
  - The requester drops i_FETCH_REQ on the cycle it sees ACK.
  - The FSM ignores i_FETCH_REQ during the ACK cycle, so no double grant occurs.
- Outside active states: o_CA keeps its last value, o_CD keeps its last value, o_CD_OE=0, WR=1.
- o_nRAM_WR is low only in W_PULSE and never low while o_nRAM_CS=1.

Test Plan:
- Reset, load ptr lo=0x34 and hi=0x05, AUTOINC=1, write 0xA5 -> CA=0x534, CD=0xA5 during W_SETUP; WR low exactly 2 clks; ptr=0x535 afterwards; BUSY high 4 clks.
- Write 0x11 then 0x22 with AUTOINC=1 from ptr=0x7FF, then reload ptr=0x7FF and read twice -> writes hit 0x7FF then 0x000 (wrap); RDATA 0x11 then 0x22, each with a one-cycle VLD.
- Hold FETCH_REQ with FA=0x100 and pulse DATA_WE the same cycle -> fetch served first (ACK, FETCH_DATA=RAM[0x100]); host write starts the cycle after the fetch returns to IDLE; no OVERRUN.
- Pulse DATA_WE twice 1 clk apart -> second dropped, OVERRUN pulses once, only one WR pulse.
- Assert i_RST during W_PULSE -> next edge WR=1, CS=1, BUSY=0, ptr=0; no further WR pulse.
- AUTOINC=0 with ADDR_LO_WE=0x10 during a write -> in-flight write uses the old ptr; ptr=0x010 afterwards and is not incremented.
